// File: rtl/div16u_8_seq.sv
// Sequential unsigned 16/8 restoring divider with a valid/ready handshake.
// TRUNC low quotient bits are skipped for a shorter, approximate result.
module div16u_8_seq #(
  parameter int TRUNC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] N,
  input  logic [7:0]  D,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  Q,
  output logic [15:0] R,
  output logic        dz,
  output logic        ovf
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [2:0] LAST_BIT = 3'(TRUNC);

  state_t      r_state;
  logic [15:0] r_p;
  logic [7:0]  r_d;
  logic [7:0]  r_q;
  logic [2:0]  r_i;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_dz;
  logic        r_ovf;

  logic [15:0] w_dsh;
  logic        w_ge;
  logic [15:0] w_diff;

  // The caller guarantees N[15:8] < D on this path, so D<<i fits in 15 bits.
  assign w_dsh  = {8'd0, r_d} << r_i;
  assign w_ge   = (r_p >= w_dsh);
  assign w_diff = r_p - w_dsh;

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_p         <= '0;
      r_d         <= '0;
      r_q         <= '0;
      r_i         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_d        <= D;
            r_p        <= N;
            r_in_ready <= 1'b0;
            if (D == 8'd0) begin
              r_state     <= S_DONE;
              r_q         <= 8'hFF;
              r_dz        <= 1'b1;
              r_ovf       <= 1'b0;
              r_out_valid <= 1'b1;
            end else if (N[15:8] >= D) begin
              r_state     <= S_DONE;
              r_q         <= 8'hFF;
              r_dz        <= 1'b0;
              r_ovf       <= 1'b1;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_BUSY;
              r_q     <= '0;
              r_i     <= 3'd7;
              r_dz    <= 1'b0;
              r_ovf   <= 1'b0;
            end
          end
        end

        S_BUSY: begin
          r_q[r_i] <= w_ge;
          if (w_ge) r_p <= w_diff;
          r_i <= r_i - 3'd1;
          if (r_i == LAST_BIT) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign Q         = r_q;
  assign R         = r_p;
  assign dz        = r_dz;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_div16u_8_seq.sv
// Scoreboard bench for div16u_8_seq: an exact instance (TRUNC=0) and an
// approximate instance (TRUNC=2) sharing operand and reset stimulus.
module tb_div16u_8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] n_in;
  logic [7:0]  d_in;
  logic        iv0, iv2, ordy0, ordy2;
  logic        ir0, ov0, dz0, ovf0;
  logic        ir2, ov2, dz2, ovf2;
  logic [7:0]  q0, q2;
  logic [15:0] r0, r2;

  always #5 clk = ~clk;

  div16u_8_seq #(.TRUNC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .N(n_in), .D(d_in),
    .out_valid(ov0), .out_ready(ordy0), .Q(q0), .R(r0), .dz(dz0), .ovf(ovf0)
  );

  div16u_8_seq #(.TRUNC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .N(n_in), .D(d_in),
    .out_valid(ov2), .out_ready(ordy2), .Q(q2), .R(r2), .dz(dz2), .ovf(ovf2)
  );

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  q;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Reference model pushes the expected result, then drives one accept.
  // inst is the instance selector and also that instance's TRUNC value.
  task automatic issue(input int inst, input logic [15:0] n, input logic [7:0] d);
    exp_t       e;
    logic [7:0] qq;
    e.n = n; e.d = d; e.dz = 1'b0; e.ovf = 1'b0;
    if (d == 8'd0) begin
      e.q = 8'hFF; e.r = n; e.dz = 1'b1;
    end else if (n[15:8] >= d) begin
      e.q = 8'hFF; e.r = n; e.ovf = 1'b1;
    end else begin
      qq  = 8'(n / d);
      qq  = qq & ~8'((1 << inst) - 1);
      e.q = qq;
      e.r = n - ({8'd0, qq} * {8'd0, d});
    end
    sb.push_back(e);
    @(negedge clk);
    n_in = n;
    d_in = d;
    if (inst == 0) iv0 = 1'b1; else iv2 = 1'b1;
    check("in_ready_at_accept", (inst == 0) ? ir0 : ir2, 1);
    @(negedge clk);
    iv0 = 1'b0;
    iv2 = 1'b0;
  endtask

  // Wait for out_valid, compare against the scoreboard, optionally stall the
  // consumer for `hold` cycles, then acknowledge.
  task automatic collect(input int inst, input int exp_lat, input int hold);
    int          lat;
    exp_t        e;
    logic [7:0]  q;
    logic [15:0] r;
    logic        f_dz, f_ovf;
    lat = 1;
    while (!((inst == 0) ? ov0 : ov2) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (exp_lat > 0) check("latency", lat, exp_lat);
    else check("done_in_time", (lat < 40) ? 1 : 0, 1);
    e     = sb.pop_front();
    q     = (inst == 0) ? q0 : q2;
    r     = (inst == 0) ? r0 : r2;
    f_dz  = (inst == 0) ? dz0 : dz2;
    f_ovf = (inst == 0) ? ovf0 : ovf2;
    check("Q", q, e.q);
    check("R", r, e.r);
    check("dz", f_dz, e.dz);
    check("ovf", f_ovf, e.ovf);
    if (!e.dz && !e.ovf) begin
      check("n_eq_qd_plus_r", 32'(q) * 32'(e.d) + 32'(r), 32'(e.n));
      check("r_bound", (32'(r) < (32'(e.d) << inst)) ? 1 : 0, 1);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (inst == 0)
        check("hold", {q0, r0, dz0, ovf0, ov0, ir0}, {q, r, f_dz, f_ovf, 1'b1, 1'b0});
      else
        check("hold", {q2, r2, dz2, ovf2, ov2, ir2}, {q, r, f_dz, f_ovf, 1'b1, 1'b0});
      n_in = ~n_in;
      d_in = d_in + 8'd1;
      if (inst == 0) iv0 = (h % 2 == 0); else iv2 = (h % 2 == 0);
    end
    iv0 = 1'b0;
    iv2 = 1'b0;
    if (inst == 0) ordy0 = 1'b1; else ordy2 = 1'b1;
    @(negedge clk);
    ordy0 = 1'b0;
    ordy2 = 1'b0;
    check("ack_in_ready", (inst == 0) ? ir0 : ir2, 1);
    check("ack_out_valid", (inst == 0) ? ov0 : ov2, 0);
  endtask

  task automatic do_op(input int inst, input logic [15:0] n, input logic [7:0] d,
                       input int exp_lat);
    issue(inst, n, d);
    collect(inst, exp_lat, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        saw;
    logic [7:0]  rd;
    logic [15:0] rn;
    rst_n = 1'b0; iv0 = 1'b0; iv2 = 1'b0; ordy0 = 1'b0; ordy2 = 1'b0;
    n_in = '0; d_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_dut0", {ir0, ov0, q0, r0, dz0, ovf0}, {1'b1, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0});
    check("reset_dut2", {ir2, ov2, q2, r2, dz2, ovf2}, {1'b1, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0});

    do_op(0, 16'd12345, 8'd123, 9);
    do_op(0, 16'h1234, 8'd0, 1);
    do_op(0, 16'hFE01, 8'hFF, 9);
    do_op(0, 16'hFF00, 8'hFF, 1);
    do_op(0, 16'd65535, 8'd1, 1);
    do_op(0, 16'd255, 8'd1, 9);

    // Consumer stall with ignored in_valid pulses, then a fresh operation.
    issue(0, 16'd40000, 8'd200);
    collect(0, 9, 5);
    do_op(0, 16'd999, 8'd10, 9);

    // Reset during the third BUSY cycle discards the in-flight result.
    issue(0, 16'd5000, 8'd9);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_state", {ir0, ov0, q0, r0, dz0, ovf0}, {1'b1, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0});
    void'(sb.pop_back());
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw = saw | ov0;
    end
    check("no_stale_result", saw, 0);
    do_op(0, 16'd1000, 8'd7, 9);

    // Approximate instance.
    do_op(2, 16'd1000, 8'd7, 7);
    do_op(2, 16'h1234, 8'd0, 1);
    do_op(2, 16'hFE01, 8'hFF, 7);
    for (int k = 0; k < 1500; k++) begin
      if (k % 50 == 49) begin
        rn = 16'($urandom);
        rd = 8'($urandom);
      end else begin
        rd = 8'($urandom_range(1, 255));
        rn = 16'($urandom_range(0, int'(rd) * 256 - 1));
      end
      do_op(2, rn, rd, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
